// File: rtl/alu_operand_stage_pkg.sv
// ALU operand stage shared constants.
// Operand source encodings and skid buffer states.
package alu_operand_stage_pkg;

    localparam logic [1:0] ALU_A_SRC_RD1_BUF = 2'd0;
    localparam logic [1:0] ALU_A_SRC_PC      = 2'd1;
    localparam logic [1:0] ALU_A_SRC_OLD_PC  = 2'd2;
    localparam logic [1:0] ALU_A_SRC_ZERO    = 2'd3;

    localparam logic [1:0] ALU_B_SRC_RD2_BUF = 2'd0;
    localparam logic [1:0] ALU_B_SRC_IMM     = 2'd1;
    localparam logic [1:0] ALU_B_SRC_CONST   = 2'd2;
    localparam logic [1:0] ALU_B_SRC_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Operand stage bus: upstream selects/sources and
// downstream ALU operand handshake.
interface alu_operand_stage_if #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] alu_a_src;
    logic [SEL_W-1:0] alu_b_src;
    logic [XLEN-1:0]  src_rd1_buf;
    logic [XLEN-1:0]  src_rd2_buf;
    logic [XLEN-1:0]  src_imm;
    logic [XLEN-1:0]  src_pc;
    logic [XLEN-1:0]  src_old_pc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic             sel_err;

    modport slave (
        input  in_valid, alu_a_src, alu_b_src,
        input  src_rd1_buf, src_rd2_buf, src_imm,
        input  src_pc, src_old_pc, out_ready,
        output in_ready, out_valid, alu_a, alu_b,
        output sel_err
    );

    modport master (
        output in_valid, alu_a_src, alu_b_src,
        output src_rd1_buf, src_rd2_buf, src_imm,
        output src_pc, src_old_pc, out_ready,
        input  in_ready, out_valid, alu_a, alu_b,
        input  sel_err
    );

endinterface

// File: rtl/alu_operand_stage_skid_buf.sv
// Two-entry skid buffer: main register drives the
// outputs, skid register absorbs one stalled pair.
module operand_skid_buf
    import alu_operand_stage_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         accept_o
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         consume;

    assign in_ready_o  = (state_q != SKID_FULL);
    assign out_valid_o = (state_q != SKID_EMPTY);
    assign out_data_o  = main_q;
    assign accept_o    = in_valid_i && in_ready_o && !flush_i;
    assign consume     = out_valid_o && out_ready_i && !flush_i;

    // Next state and data movement; flush drops everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = SKID_EMPTY;
        end else begin
            unique case (state_q)
                SKID_EMPTY: begin
                    if (accept_o) begin
                        main_d  = in_data_i;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept_o && consume) begin
                        main_d = in_data_i;
                    end else if (accept_o) begin
                        skid_d  = in_data_i;
                        state_d = SKID_FULL;
                    end else if (consume) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand select: picks A and B from
// the datapath buffers and queues them for the ALU.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter int unsigned B_CONST = 4,
    parameter int          SEL_W   = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic flush,
    alu_operand_stage_if.slave bus
);

    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [2*XLEN-1:0] pair_out;
    logic              accept;
    logic              ill_b;
    logic              sel_err_q, sel_err_d;

    // Operand A source select.
    always_comb begin
        op_a = '0;
        case (bus.alu_a_src)
            SEL_W'(ALU_A_SRC_RD1_BUF): op_a = bus.src_rd1_buf;
            SEL_W'(ALU_A_SRC_PC):      op_a = bus.src_pc;
            SEL_W'(ALU_A_SRC_OLD_PC):  op_a = bus.src_old_pc;
            default:                   op_a = '0;
        endcase
    end

    // Operand B source select; the illegal code yields zero.
    always_comb begin
        op_b = '0;
        case (bus.alu_b_src)
            SEL_W'(ALU_B_SRC_RD2_BUF): op_b = bus.src_rd2_buf;
            SEL_W'(ALU_B_SRC_IMM):     op_b = bus.src_imm;
            SEL_W'(ALU_B_SRC_CONST):   op_b = XLEN'(B_CONST);
            default:                   op_b = '0;
        endcase
    end

    assign ill_b = (bus.alu_b_src == SEL_W'(ALU_B_SRC_ILLEGAL));

    operand_skid_buf #(
        .W (2*XLEN)
    ) u_skid (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (flush),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   ({op_a, op_b}),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (pair_out),
        .accept_o    (accept)
    );

    assign bus.alu_a   = pair_out[2*XLEN-1:XLEN];
    assign bus.alu_b   = pair_out[XLEN-1:0];
    assign bus.sel_err = sel_err_q;

    // Sticky error set when an illegal B select is accepted.
    always_comb begin
        sel_err_d = sel_err_q;
        if (accept && ill_b) begin
            sel_err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vectors plus
// randomized traffic against a queue-based model.
module tb_alu_operand_stage;

    localparam int XLEN = 32;

    logic clk;
    logic rstn;
    logic flush;

    alu_operand_stage_if #(.XLEN(XLEN), .SEL_W(2)) bus ();

    alu_operand_stage #(
        .XLEN    (XLEN),
        .B_CONST (4),
        .SEL_W   (2)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  a_src;
        logic [1:0]  b_src;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] opc;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t        vecs[6];
    logic [63:0] mq[$];
    bit          err_m;
    int          errors;
    int          checks;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_a();
        case (bus.alu_a_src)
            2'd0:    return bus.src_rd1_buf;
            2'd1:    return bus.src_pc;
            2'd2:    return bus.src_old_pc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_b();
        case (bus.alu_b_src)
            2'd0:    return bus.src_rd2_buf;
            2'd1:    return bus.src_imm;
            2'd2:    return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_model();
        chk("in_ready", {63'd0, bus.in_ready},
            {63'd0, mq.size() < 2});
        chk("out_valid", {63'd0, bus.out_valid},
            {63'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk("alu_a", {32'd0, bus.alu_a},
                {32'd0, mq[0][63:32]});
            chk("alu_b", {32'd0, bus.alu_b},
                {32'd0, mq[0][31:0]});
        end
        chk("sel_err", {63'd0, bus.sel_err},
            {63'd0, err_m});
    endtask

    task automatic step();
        bit          acc;
        bit          con;
        logic [63:0] p;
        logic [63:0] drop;
        acc = bus.in_valid && (mq.size() < 2) && !flush;
        con = bus.out_ready && (mq.size() > 0) && !flush;
        p = {ref_a(), ref_b()};
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (con) drop = mq.pop_front();
            if (acc) begin
                mq.push_back(p);
                if (bus.alu_b_src == 2'd3) err_m = 1'b1;
            end
        end
        #1;
        check_model();
    endtask

    task automatic drive(input logic [1:0] a,
                         input logic [1:0] b,
                         input logic [31:0] rd1,
                         input logic [31:0] rd2,
                         input logic [31:0] imm,
                         input logic [31:0] pc,
                         input logic [31:0] opc);
        bus.alu_a_src   = a;
        bus.alu_b_src   = b;
        bus.src_rd1_buf = rd1;
        bus.src_rd2_buf = rd2;
        bus.src_imm     = imm;
        bus.src_pc      = pc;
        bus.src_old_pc  = opc;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        err_m  = 1'b0;
        rstn   = 1'b0;
        flush  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(2'd0, 2'd0, 0, 0, 0, 0, 0);

        vecs[0] = '{2'd1, 2'd2, 32'h1, 32'h2, 32'h3,
                    32'h100, 32'h5, 32'h100, 32'h4};
        vecs[1] = '{2'd0, 2'd0, 32'hA5A5_0001,
                    32'h5A5A_0002, 32'h3, 32'h4, 32'h5,
                    32'hA5A5_0001, 32'h5A5A_0002};
        vecs[2] = '{2'd2, 2'd1, 32'h1, 32'h2,
                    32'hFFFF_FFF0, 32'h4, 32'h8000_0000,
                    32'h8000_0000, 32'hFFFF_FFF0};
        vecs[3] = '{2'd3, 2'd0, 32'h55, 32'h66, 32'h7,
                    32'h8, 32'h9, 32'h0, 32'h66};
        vecs[4] = '{2'd1, 2'd1, 32'h1, 32'h2, 32'h0,
                    32'hFFFF_FFFF, 32'h9, 32'hFFFF_FFFF,
                    32'h0};
        vecs[5] = '{2'd0, 2'd2, 32'h0, 32'h2, 32'h3,
                    32'h4, 32'h5, 32'h0, 32'h4};

        #3;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_alu_a", {32'd0, bus.alu_a}, 64'd0);
        chk("rst_alu_b", {32'd0, bus.alu_b}, 64'd0);
        chk("rst_sel_err", {63'd0, bus.sel_err}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].a_src, vecs[i].b_src,
                  vecs[i].rd1, vecs[i].rd2, vecs[i].imm,
                  vecs[i].pc, vecs[i].opc);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            step();
            chk($sformatf("vec%0d_a", i), {32'd0, bus.alu_a},
                {32'd0, vecs[i].ea});
            chk($sformatf("vec%0d_b", i), {32'd0, bus.alu_b},
                {32'd0, vecs[i].eb});
            bus.in_valid = 1'b0;
            step();
            chk($sformatf("vec%0d_drain", i),
                {63'd0, bus.out_valid}, 64'd0);
        end

        bus.out_ready = 1'b0;
        drive(2'd0, 2'd0, 32'h11, 32'h22, 0, 0, 0);
        bus.in_valid = 1'b1;
        step();
        drive(2'd0, 2'd0, 32'h33, 32'h44, 0, 0, 0);
        step();
        chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("bp_hold_a", {32'd0, bus.alu_a}, 64'h11);
        chk("bp_hold_b", {32'd0, bus.alu_b}, 64'h22);
        bus.in_valid = 1'b0;
        step();
        chk("bp_hold2_a", {32'd0, bus.alu_a}, 64'h11);
        bus.out_ready = 1'b1;
        step();
        chk("bp_skid_a", {32'd0, bus.alu_a}, 64'h33);
        chk("bp_skid_b", {32'd0, bus.alu_b}, 64'h44);
        step();
        chk("bp_empty", {63'd0, bus.out_valid}, 64'd0);

        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(2'd0, 2'd1, 0, 0, i, 0, 0);
            step();
            chk($sformatf("stream%0d_b", i),
                {32'd0, bus.alu_b}, i);
            chk($sformatf("stream%0d_rdy", i),
                {63'd0, bus.in_ready}, 64'd1);
        end
        bus.in_valid = 1'b0;
        step();

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(2'd0, 2'd0, 32'h71, 32'h72, 0, 0, 0);
        step();
        drive(2'd0, 2'd0, 32'h73, 32'h74, 0, 0, 0);
        step();
        chk("fl_full", {63'd0, bus.in_ready}, 64'd0);
        drive(2'd0, 2'd0, 32'hBAD0, 32'hBAD1, 0, 0, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("fl_in_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) step();
        chk("fl_nothing", {63'd0, bus.out_valid}, 64'd0);

        drive(2'd0, 2'd3, 32'h1, 32'hDEAD_BEEF, 0, 0, 0);
        bus.in_valid = 1'b1;
        step();
        chk("ill_b", {32'd0, bus.alu_b}, 64'd0);
        chk("ill_err", {63'd0, bus.sel_err}, 64'd1);
        bus.in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ill_err_flush", {63'd0, bus.sel_err}, 64'd1);
        drive(2'd3, 2'd0, 32'h55, 32'h66, 0, 0, 0);
        bus.in_valid = 1'b1;
        step();
        chk("zero_a", {32'd0, bus.alu_a}, 64'd0);
        chk("zero_a_err", {63'd0, bus.sel_err}, 64'd1);
        bus.in_valid = 1'b0;
        step();

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(2'd0, 2'd0, 32'h91, 32'h92, 0, 0, 0);
        step();
        drive(2'd0, 2'd0, 32'h93, 32'h94, 0, 0, 0);
        step();
        chk("ar_full", {63'd0, bus.in_ready}, 64'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("ar_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("ar_sel_err", {63'd0, bus.sel_err}, 64'd0);
        mq.delete();
        err_m = 1'b0;
        bus.in_valid = 1'b0;
        #3;
        rstn = 1'b1;

        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom_range(3)), 2'($urandom_range(3)),
                  $urandom, $urandom, $urandom,
                  $urandom, $urandom);
            bus.in_valid  = 1'($urandom_range(1));
            bus.out_ready = 1'($urandom_range(1));
            flush = ($urandom_range(31) == 0);
            step();
        end
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised, registered successor to the combinational ALU operand-B select.
- Selects both ALU operands (A and B) from the datapath buffers and captures them into a 2-entry skid buffer with a valid/ready handshake.
- Lets the ALU input be pipelined or stalled without losing an operand pair.
- Sits between the register-file/immediate buffers and the ALU; the control unit drives the selects and in_valid.

Parameters:
- XLEN, 32, datapath width of all sources and outputs.
- B_CONST, 4, constant driven when alu_b_src selects the constant (PC increment).
- SEL_W, 2, width of alu_a_src and alu_b_src.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  upstream offers an operand pair this cycle.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready.
- alu_a_src  in  SEL_W  A select: 0=RD1_BUF, 1=PC, 2=OLD_PC, 3=ZERO.
- alu_b_src  in  SEL_W  B select: 0=RD2_BUF, 1=IMM, 2=CONST (B_CONST), 3=illegal.
- src_rd1_buf, src_rd2_buf, src_imm, src_pc, src_old_pc  in  XLEN each  operand sources.
- out_valid  out  1  alu_a/alu_b hold a valid pair.
- out_ready  in  1  ALU consumes; a transfer occurs when out_valid && out_ready.
- alu_a, alu_b  out  XLEN  registered operands.
- sel_err  out  1  sticky flag: an illegal select was accepted.

Behaviour:
- Reset (rstn low, asynchronous): out_valid=0, in_ready=1, alu_a=0, alu_b=0, sel_err=0, skid entry invalid.
- Selection is combinational on the input side; the result is registered on acceptance. Latency is 1 cycle from an accepted input to out_valid.
- Illegal B select (3): the operand is captured as 0, and sel_err is set on acceptance. sel_err clears only on reset.
- Storage is a main register (drives outputs) plus one skid register.
- State machine:
  - EMPTY: main invalid, skid invalid. in_ready=1. Accept → ONE.
  - ONE: main valid.
    - Accept with consume → ONE; main reloads with the new pair.
    - Accept without consume → FULL; new pair goes to skid.
    - Consume without accept → EMPTY.
    - Neither → ONE, outputs held stable.
  - FULL: main and skid valid. in_ready=0.
    - Consume → ONE; skid moves to main.
    - No consume → FULL, outputs held.
- in_ready is registered: it equals !skid_valid, with no combinational path from out_ready.
- While out_valid=1 and out_ready=0, alu_a/alu_b must not change.
- flush (synchronous) has priority over all transfers. Next cycle: EMPTY, out_valid=0, in_ready=1, and any same-cycle input is dropped. Data registers may keep stale values. sel_err is not cleared by flush.
- Reset mid-operation discards all entries immediately.
- Arithmetic: none. B_CONST is zero-extended or truncated to XLEN.

Decomposition:
- Shared constants header: ALU_A_SRC_* and ALU_B_SRC_* encodings, alongside the existing ALU source constants.
- One sub-module: operand_skid_buf (2-entry, 2×XLEN payload, valid/ready), instantiated once. Select logic stays in the top.

Test Plan:
- Reset then single transfer: a_src=1, src_pc=0x100, b_src=2, in_valid for 1 cycle, out_ready=1 → next cycle out_valid=1, alu_a=0x100, alu_b=0x4; following cycle out_valid=0.
- Backpressure: out_ready=0; push pairs (rd1=0x11, rd2=0x22) then (0x33, 0x44) → in_ready drops to 0 after the second push; outputs hold 0x11/0x22. Raise out_ready → 0x33/0x44 appear next cycle, then out_valid=0; no loss or duplication.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with imm=0..7, b_src=1 → alu_b sequence 0..7 on consecutive cycles, in_ready constantly 1.
- Illegal select: b_src=3, rd2=0xDEADBEEF accepted → alu_b=0, sel_err=1, and sel_err still 1 after a flush. a_src=3 → alu_a=0, sel_err unaffected.
- Flush in FULL: fill both entries, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, nothing from the dropped input ever emerges.
- Async reset mid-stream: drop rstn between clock edges while in FULL → out_valid=0 and in_ready=1 immediately, before the next edge.
